// File: rtl/cut_sweep_controller.sv
// Exhaustive input sweep of a combinational CUT with MISR compaction and a golden compare.
// Each vector costs SETTLE+1 cycles. There is no backpressure: start is ignored while busy.
module cut_sweep_controller #(
  parameter int               N_IN   = 2,
  parameter int               N_OUT  = 8,
  parameter int               SIG_W  = 16,
  parameter int               SETTLE = 1,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SIG_W-1:0] golden,
  output logic [N_IN-1:0]  cut_x,
  input  logic [N_OUT-1:0] cut_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE_ST = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [SIG_W-1:0] golden_q;
  logic [SIG_W-1:0] f_ext;
  logic [SIG_W-1:0] sig_next;
  logic             last_vec;

  assign last_vec = (cut_x == {N_IN{1'b1}});
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Zero-extend CUT outputs so N_OUT == SIG_W needs no special case
  always_comb begin
    f_ext              = '0;
    f_ext[N_OUT-1:0]   = cut_f;
  end

  assign sig_next = (signature << 1) ^ (signature[SIG_W-1] ? POLY : '0) ^ f_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = SETTLE_ST;
      SETTLE_ST: if (cnt == CNT_LAST) state_n = SAMPLE;
      SAMPLE:    state_n = last_vec ? DONE : SETTLE_ST;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cut_x     <= '0;
      signature <= SEED;
      cnt       <= '0;
      golden_q  <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cut_x     <= '0;
            signature <= SEED;
            cnt       <= '0;
            golden_q  <= golden;
            pass      <= 1'b0;
          end
        end
        SETTLE_ST: begin
          if (cnt == CNT_LAST) cnt <= '0;
          else                 cnt <= cnt + CNT_W'(1);
        end
        SAMPLE: begin
          signature <= sig_next;
          // Last vector: cut_x stays all-ones rather than wrapping
          if (last_vec) pass  <= (sig_next == golden_q);
          else          cut_x <= cut_x + N_IN'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cut_sweep_controller.sv
// Directed checks of the sweep controller: zero CUT and identity CUT instances sharing clock and reset.
module tb_cut_sweep_controller;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  logic        start_a, start_b;
  logic [15:0] golden_a, golden_b;
  logic [1:0]  cut_x_a, cut_x_b;
  logic [7:0]  cut_f_a, cut_f_b;
  logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [15:0] sig_a, sig_b;

  logic [15:0] sig_tab [4];

  always #5 clk = ~clk;

  assign cut_f_a = 8'h00;
  assign cut_f_b = {6'b0, cut_x_b};

  cut_sweep_controller dut_a (
    .clk(clk), .rst(rst), .start(start_a), .golden(golden_a), .cut_x(cut_x_a),
    .cut_f(cut_f_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a)
  );

  cut_sweep_controller #(.SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .golden(golden_b), .cut_x(cut_x_b),
    .cut_f(cut_f_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    golden_a = 16'h0; golden_b = 16'h0;
    tick(); tick();
    checks++; if (cut_x_a !== 2'd0)     begin errors++; $display("FAIL reset_cut_x got %h want 0", cut_x_a); end
    checks++; if (sig_a !== 16'hFFFF)   begin errors++; $display("FAIL reset_sig got %h want FFFF", sig_a); end
    checks++; if (busy_a !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
    checks++; if (pass_a !== 1'b0)      begin errors++; $display("FAIL reset_pass got %b want 0", pass_a); end
    checks++; if (sig_b !== 16'hFFFF)   begin errors++; $display("FAIL reset_sig_b got %h want FFFF", sig_b); end
    checks++; if (busy_b !== 1'b0)      begin errors++; $display("FAIL reset_busy_b got %b want 0", busy_b); end
    rst = 1'b0;
    tick();
    checks++; if (busy_a !== 1'b0)      begin errors++; $display("FAIL idle_busy got %b want 0", busy_a); end
  endtask

  // Default instance, zero CUT: edge 0 accepts start, done after edge 8
  task automatic test_zero_cut(input logic [15:0] gold, input logic exp_pass);
    logic [1:0] exp_x;
    golden_a = gold;
    start_a  = 1'b1;
    tick();
    start_a  = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_x = (i >= 6) ? 2'd3 : 2'(i / 2);
      checks++; if (done_a !== (i == 8)) begin errors++; $display("FAIL zero_done e%0d got %b want %b", i, done_a, (i == 8)); end
      checks++; if (busy_a !== (i <= 8)) begin errors++; $display("FAIL zero_busy e%0d got %b want %b", i, busy_a, (i <= 8)); end
      checks++; if (cut_x_a !== exp_x)   begin errors++; $display("FAIL zero_cut_x e%0d got %0d want %0d", i, cut_x_a, exp_x); end
      if (i % 2 == 0 && i <= 8) begin
        checks++; if (sig_a !== sig_tab[i/2-1]) begin errors++; $display("FAIL zero_sig e%0d got %h want %h", i, sig_a, sig_tab[i/2-1]); end
      end
      if (i >= 8) begin
        checks++; if (pass_a !== exp_pass) begin errors++; $display("FAIL zero_pass e%0d got %b want %b", i, pass_a, exp_pass); end
        checks++; if (sig_a !== 16'h0E1F)  begin errors++; $display("FAIL zero_final_sig e%0d got %h want 0E1F", i, sig_a); end
      end
    end
  endtask

  // SETTLE=3, identity CUT: vectors held 4 cycles, expected signature 0E1C
  task automatic test_identity();
    golden_b = 16'h0E1C;
    start_b  = 1'b1;
    tick();
    start_b  = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++; if (done_b !== (i == 16)) begin errors++; $display("FAIL id_done e%0d got %b want %b", i, done_b, (i == 16)); end
      checks++; if (busy_b !== (i <= 16)) begin errors++; $display("FAIL id_busy e%0d got %b want %b", i, busy_b, (i <= 16)); end
      if (i == 3) begin
        checks++; if (cut_x_b !== 2'd0) begin errors++; $display("FAIL id_cut_x_hold got %0d want 0", cut_x_b); end
      end
      if (i == 4) begin
        checks++; if (cut_x_b !== 2'd1)    begin errors++; $display("FAIL id_cut_x_step got %0d want 1", cut_x_b); end
        checks++; if (sig_b !== 16'hEFDF)  begin errors++; $display("FAIL id_sig0 got %h want EFDF", sig_b); end
      end
      if (i == 16) begin
        checks++; if (sig_b !== 16'h0E1C) begin errors++; $display("FAIL id_sig got %h want 0E1C", sig_b); end
        checks++; if (pass_b !== 1'b1)    begin errors++; $display("FAIL id_pass got %b want 1", pass_b); end
      end
    end
  endtask

  task automatic test_restart_ignored();
    golden_a = 16'h0E1F;
    start_a  = 1'b1;
    tick();
    start_a  = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 2) start_a = 1'b1;
      if (i == 3) begin
        start_a  = 1'b0;
        golden_a = 16'h0000;
        checks++; if (cut_x_a !== 2'd1) begin errors++; $display("FAIL rs_cut_x got %0d want 1", cut_x_a); end
      end
      checks++; if (done_a !== (i == 8)) begin errors++; $display("FAIL rs_done e%0d got %b want %b", i, done_a, (i == 8)); end
      if (i == 8) begin
        checks++; if (pass_a !== 1'b1)    begin errors++; $display("FAIL rs_pass got %b want 1", pass_a); end
        checks++; if (sig_a !== 16'h0E1F) begin errors++; $display("FAIL rs_sig got %h want 0E1F", sig_a); end
      end
    end
  endtask

  task automatic test_reset_mid();
    golden_a = 16'h0E1F;
    start_a  = 1'b1;
    tick();
    start_a  = 1'b0;
    repeat (4) tick();
    checks++; if (cut_x_a !== 2'd2) begin errors++; $display("FAIL rm_pre_cut_x got %0d want 2", cut_x_a); end
    rst = 1'b1;
    #1;
    checks++; if (cut_x_a !== 2'd0)   begin errors++; $display("FAIL rm_cut_x got %0d want 0", cut_x_a); end
    checks++; if (sig_a !== 16'hFFFF) begin errors++; $display("FAIL rm_sig got %h want FFFF", sig_a); end
    checks++; if (busy_a !== 1'b0)    begin errors++; $display("FAIL rm_busy got %b want 0", busy_a); end
    checks++; if (done_a !== 1'b0)    begin errors++; $display("FAIL rm_done got %b want 0", done_a); end
    checks++; if (pass_a !== 1'b0)    begin errors++; $display("FAIL rm_pass got %b want 0", pass_a); end
    tick();
    rst = 1'b0;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (done_a !== (i == 8)) begin errors++; $display("FAIL rm_done2 e%0d got %b want %b", i, done_a, (i == 8)); end
    end
    checks++; if (sig_a !== 16'h0E1F) begin errors++; $display("FAIL rm_sig2 got %h want 0E1F", sig_a); end
    checks++; if (pass_a !== 1'b1)    begin errors++; $display("FAIL rm_pass2 got %b want 1", pass_a); end
    tick();
  endtask

  task automatic test_back_to_back();
    golden_a = 16'h0E1F;
    start_a  = 1'b1;
    tick();
    for (int i = 1; i <= 18; i++) begin
      tick();
      checks++; if (done_a !== (i == 8 || i == 18)) begin errors++; $display("FAIL bb_done e%0d got %b want %b", i, done_a, (i == 8 || i == 18)); end
      checks++; if (busy_a !== (i != 9))            begin errors++; $display("FAIL bb_busy e%0d got %b want %b", i, busy_a, (i != 9)); end
      if (i == 9) begin
        checks++; if (sig_a !== 16'h0E1F) begin errors++; $display("FAIL bb_idle_sig got %h want 0E1F", sig_a); end
        checks++; if (pass_a !== 1'b1)    begin errors++; $display("FAIL bb_idle_pass got %b want 1", pass_a); end
      end
      if (i == 10) begin
        checks++; if (sig_a !== 16'hFFFF) begin errors++; $display("FAIL bb_reseed got %h want FFFF", sig_a); end
        checks++; if (cut_x_a !== 2'd0)   begin errors++; $display("FAIL bb_cut_x got %0d want 0", cut_x_a); end
        checks++; if (pass_a !== 1'b0)    begin errors++; $display("FAIL bb_pass_clr got %b want 0", pass_a); end
      end
      if (i == 18) begin
        checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL bb_pass2 got %b want 1", pass_a); end
      end
    end
    start_a = 1'b0;
    tick(); tick();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL bb_stop_busy got %b want 0", busy_a); end
  endtask

  initial begin
    sig_tab[0] = 16'hEFDF;
    sig_tab[1] = 16'hCF9F;
    sig_tab[2] = 16'h8F1F;
    sig_tab[3] = 16'h0E1F;
    test_reset();
    test_zero_cut(16'h0E1F, 1'b1);
    tick();
    test_zero_cut(16'h0E1E, 1'b0);
    tick();
    test_identity();
    test_restart_ignored();
    tick();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
